// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped byte FIFO drained by an 8N1 serial transmitter.
// Registers: 0 TXDATA (push), 1 STATUS, 2 DIVISOR (bit time = DIVISOR+1 clocks), 3 CONTROL.
module uart_tx_port #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd15
) (
    input  logic        clock,
    input  logic        notReset,
    input  logic        notCS,
    input  logic [1:0]  address,
    inout  wire  [15:0] data,
    input  logic        notRead,
    input  logic        notWrite,
    output logic        txd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [4:0]    count_q, count_d;
    logic          ovf_q, ovf_d, en_q, en_d, wr_seen_q, wr_seen_d;
    logic [15:0]   div_q, div_d, bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    idx_q, idx_d;
    logic          wr_act, wr_pulse, push, pop, clear, full, empty, bit_end;
    logic [15:0]   rdata;

    // A write acts only on the first edge of each strobe assertion.
    assign wr_act   = !notCS && !notWrite;
    assign wr_pulse = wr_act && !wr_seen_q;
    assign empty    = count_q == 5'd0;
    assign full     = count_q == DEPTH;
    assign pop      = state_q == IDLE && en_q && !empty;
    assign push     = wr_pulse && address == 2'd0 && (!full || pop);
    assign clear    = wr_pulse && address == 2'd3 && data[1];
    assign bit_end  = bit_cnt_q == 16'd0;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = data[7:0];
        rd_ptr_d  = clear ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d  = clear ? '0 : wr_ptr_q + AW'(push);
        count_d   = clear ? 5'd0 : count_q + 5'(push) - 5'(pop);
        ovf_d     = clear ? 1'b0 : ovf_q | (wr_pulse && address == 2'd0 && full && !pop);
        div_d     = (wr_pulse && address == 2'd2) ? data : div_q;
        en_d      = (wr_pulse && address == 2'd3) ? data[0] : en_q;
        wr_seen_d = wr_act;
    end

    // The bit counter reloads from DIVISOR at every bit boundary, so divisor writes apply to the next bit.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        bit_cnt_d = bit_end ? div_q : bit_cnt_q - 16'd1;
        txd       = 1'b1;
        case (state_q)
            IDLE: begin
                bit_cnt_d = div_q;
                if (pop) begin
                    state_d = START;
                    shift_d = mem_q[rd_ptr_q];
                end
            end
            START: begin
                txd = 1'b0;
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                txd = shift_q[idx_q];
                if (bit_end) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (address)
            2'd1:    rdata = {7'd0, ovf_q, count_q, state_q != IDLE, full, empty};
            2'd2:    rdata = div_q;
            2'd3:    rdata = {15'd0, en_q};
            default: rdata = 16'd0;
        endcase
    end

    assign data = (!notCS && !notRead && notWrite) ? rdata : 16'hzzzz;

    always_ff @(posedge clock) mem_q <= mem_d;

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= 5'd0;
            ovf_q     <= 1'b0;
            en_q      <= 1'b1;
            div_q     <= DIV_RESET;
            wr_seen_q <= 1'b0;
            bit_cnt_q <= 16'd0;
            shift_q   <= 8'd0;
            idx_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            en_q      <= en_d;
            div_q     <= div_d;
            wr_seen_q <= wr_seen_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: randomized bus traffic checked cycle by cycle against a queue-based
// model of the FIFO and of the expected serial waveform, plus literal directed checks.
module tb_uart_tx_port;
    localparam int DEPTH = 4;

    logic        clock = 0, notReset = 0, notCS = 1, notRead = 1, notWrite = 1;
    logic [1:0]  address = 0;
    wire  [15:0] data;
    logic        txd;
    logic [15:0] drv = 0;
    logic        drv_en = 0;
    logic        rec = 0;
    logic [1:0]  trace[$];
    int          checks = 0, fails = 0;

    assign data = drv_en ? drv : 16'hzzzz;

    uart_tx_port #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd15)) dut (
        .clock(clock), .notReset(notReset), .notCS(notCS), .address(address),
        .data(data), .notRead(notRead), .notWrite(notWrite), .txd(txd)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1);
    end

    // Model: FIFO as a byte queue, expected txd as a per-clock queue of levels.
    byte unsigned mq[$];
    logic         me[$];
    logic         m_ovf = 0, m_en = 1, m_prev = 0;
    logic [15:0]  m_div = 16'd15;
    logic         idle_b, full_b, pop_b, wr_b;
    logic [7:0]   byte_b;
    logic [9:0]   frame_b;

    always @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            mq.delete(); me.delete();
            m_ovf = 0; m_en = 1; m_prev = 0; m_div = 16'd15;
        end else begin
            idle_b = me.size() == 0;
            if (!idle_b) void'(me.pop_front());
            full_b = mq.size() == DEPTH;
            pop_b  = idle_b && m_en && mq.size() != 0;
            if (pop_b) begin
                byte_b  = mq.pop_front();
                frame_b = {1'b1, byte_b, 1'b0};
                for (int b = 0; b < 10; b++)
                    for (int k = 0; k <= int'(m_div); k++) me.push_back(frame_b[b]);
            end
            wr_b = !notCS && !notWrite;
            if (wr_b && !m_prev) begin
                case (address)
                    2'd0: if (full_b && !pop_b) m_ovf = 1; else mq.push_back(data[7:0]);
                    2'd2: m_div = data;
                    2'd3: begin
                        m_en = data[0];
                        if (data[1]) begin mq.delete(); m_ovf = 0; end
                    end
                    default: ;
                endcase
            end
            m_prev = wr_b;
        end
    end

    function automatic logic [15:0] exp_rd(input logic [1:0] a);
        logic [4:0] n = 5'(mq.size());
        case (a)
            2'd1:    return {7'd0, m_ovf, n, me.size() != 0, n == 5'(DEPTH), n == 5'd0};
            2'd2:    return m_div;
            2'd3:    return {15'd0, m_en};
            default: return 16'd0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        check("txd", 32'(txd), 32'(me.size() != 0 ? me[0] : 1'b1));
        if (!notCS && !notRead && notWrite) check("read", 32'(data), 32'(exp_rd(address)));
        if (rec) trace.push_back({data[2], txd});
    end

    task automatic idle(input int n);
        notWrite = 1; drv_en = 0; notCS = 0; notRead = 0; address = 2'd1;
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d, input int hold = 1);
        notRead = 1; notCS = 0; address = a; drv = d; drv_en = 1; notWrite = 0;
        repeat (hold) @(posedge clock);
        #2;
        notWrite = 1; drv_en = 0;
        idle(1);
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] e, input string nm);
        notWrite = 1; drv_en = 0; notCS = 0; notRead = 0; address = a;
        #1;
        check(nm, 32'(data), 32'(e));
        @(posedge clock);
        #2;
    endtask

    // Locate the first low txd sample in the trace and compare n clocks of txd/busy plus the idle clock after.
    task automatic frame_check(input string nm, input int n, input logic [31:0] ptx, input logic [31:0] pbusy);
        int s = -1;
        logic [31:0] gtx = 0, gbusy = 0;
        for (int i = 0; i < trace.size(); i++) if (s < 0 && trace[i][0] == 1'b0) s = i;
        check({nm, "_found"}, 32'(s >= 0 && s + n < trace.size()), 32'd1);
        if (s >= 0 && s + n < trace.size()) begin
            for (int i = 0; i < n; i++) begin
                gtx   = {gtx[30:0], trace[s+i][0]};
                gbusy = {gbusy[30:0], trace[s+i][1]};
            end
            check({nm, "_txd"}, gtx, ptx);
            check({nm, "_busy"}, gbusy, pbusy);
            check({nm, "_after"}, 32'(trace[s+n]), 32'd1);
        end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #2;
        notReset = 1;
        idle(2);
        check("rst_txd", 32'(txd), 32'd1);
        rd(2'd1, 16'h0001, "rst_status");
        rd(2'd2, 16'd15, "rst_divisor");
        rd(2'd3, 16'h0001, "rst_control");

        wr(2'd2, 16'd1);
        trace.delete(); rec = 1;
        wr(2'd0, 16'h00A5);
        idle(25);
        rec = 0;
        frame_check("single", 20, 32'b00110011000011001111, 32'hFFFFF);

        wr(2'd3, 16'h0000);
        wr(2'd0, 16'h0041, 5);
        rd(2'd1, 16'h0008, "long_strobe");
        for (int i = 0; i < 4; i++) wr(2'd0, 16'(8'h30 + i));
        rd(2'd1, 16'h0122, "overflow");
        wr(2'd3, 16'h0003);
        rd(2'd1, 16'h0001, "clear");
        wr(2'd0, 16'h005A);
        idle(25);
        rd(2'd1, 16'h0001, "resume_done");

        wr(2'd2, 16'd0);
        wr(2'd3, 16'h0000);
        wr(2'd0, 16'h0055);
        wr(2'd0, 16'h000F);
        trace.delete(); rec = 1;
        wr(2'd3, 16'h0001);
        idle(30);
        rec = 0;
        frame_check("b2b", 21, 32'b010101010110111100001, 32'b111111111101111111111);

        for (int it = 0; it < 150; it++) begin
            int r = $urandom_range(0, 99);
            if (r < 50) wr(2'd0, 16'($urandom_range(0, 65535)), $urandom_range(1, 3));
            else if (r < 60) wr(2'd3, ($urandom_range(0, 3) != 0) ? 16'h0001 : 16'h0000);
            else if (r < 64) wr(2'd3, 16'h0003);
            else if (r < 72 && me.size() == 0 && mq.size() == 0) wr(2'd2, 16'($urandom_range(0, 3)));
            else idle($urandom_range(1, 20));
        end
        wr(2'd3, 16'h0001);
        for (int i = 0; i < 2000 && (me.size() != 0 || mq.size() != 0); i++) idle(1);
        check("drain_timeout", 32'(me.size() != 0 || mq.size() != 0), 32'd0);
        idle(2);
        rd(2'd1, 16'h0001, "drained");

        wr(2'd2, 16'd1);
        wr(2'd0, 16'h00A5);
        idle(9);
        check("pre_rst_txd", 32'(txd), 32'd0);
        #1 notReset = 0;
        #1;
        check("rst_async_txd", 32'(txd), 32'd1);
        check("rst_async_status", 32'(data), 32'h0001);
        @(posedge clock);
        #2;
        notReset = 1;
        idle(2);
        rd(2'd1, 16'h0001, "post_rst_status");
        rd(2'd2, 16'd15, "post_rst_divisor");
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
